// File: rtl/perm_decode.sv
// Permutation de-enumerator: rebuilds an N-element permutation from its
// lexicographic (factoradic) rank, resolving one position per clock.
module perm_decode #(
    parameter int N  = 4,
    parameter int W  = $clog2(N),
    parameter int IW = $clog2(N == 2 ? 2 :
                               N == 3 ? 6 :
                               N == 4 ? 24 :
                               N == 5 ? 120 :
                               N == 6 ? 720 :
                               N == 7 ? 5040 : 40320)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            idx_valid,
    output logic            idx_ready,
    input  logic [IW-1:0]   idx,
    output logic            prm_valid,
    input  logic            prm_ready,
    output logic [N*W-1:0]  prm,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } state_t;

    // Factorial table; n never exceeds 8 here.
    function automatic logic [31:0] fact(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= 8; i++) begin
            if (i <= n) r = r * 32'(i);
        end
        return r;
    endfunction

    localparam logic [31:0] NF = fact(N);

    state_t          state;
    state_t          nxt;
    logic [IW-1:0]   rem;
    logic [IW-1:0]   rem_n;
    logic [N-1:0]    used;
    logic [N-1:0]    used_n;
    logic [W-1:0]    pos;
    logic [N*W-1:0]  work;
    logic [N*W-1:0]  work_n;
    logic [N*W-1:0]  ident;
    logic            bad;
    logic            accept;
    logic            last;
    logic [31:0]     f;
    logic [31:0]     d;
    logic [31:0]     prod;
    logic [31:0]     cnt;
    logic [W-1:0]    val;

    assign accept = idx_valid && idx_ready && (state == IDLE);
    assign last   = (pos == W'(N - 1));

    // Digit extraction by comparison ladder and d-th unused value pick.
    always_comb begin
        f    = fact(N - 1 - int'(pos));
        d    = '0;
        prod = '0;
        for (int j = 1; j < N; j++) begin
            if (32'(rem) >= 32'(j) * f) begin
                d    = 32'(j);
                prod = 32'(j) * f;
            end
        end
        rem_n = IW'(32'(rem) - prod);
        val   = '0;
        cnt   = '0;
        for (int v = 0; v < N; v++) begin
            if (!used[v]) begin
                if (cnt == d) val = W'(v);
                cnt = cnt + 32'd1;
            end
        end
        work_n = work;
        work_n[int'(pos)*W +: W] = val;
        used_n = used;
        used_n[val] = 1'b1;
        ident = '0;
        for (int i = 0; i < N; i++) begin
            ident[i*W +: W] = W'(i);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state selection.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (accept) nxt = DECODE;
            DECODE:  if (bad || last) nxt = DONE;
            DONE:    if (prm_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; result only copied to prm when complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_ready <= 1'b0;
            prm_valid <= 1'b0;
            prm       <= '0;
            err       <= 1'b0;
            rem       <= '0;
            used      <= '0;
            pos       <= '0;
            work      <= '0;
            bad       <= 1'b0;
        end else begin
            idx_ready <= (nxt == IDLE);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rem  <= idx;
                        used <= '0;
                        pos  <= '0;
                        work <= '0;
                        bad  <= (32'(idx) >= NF);
                    end
                end
                DECODE: begin
                    if (bad) begin
                        prm       <= ident;
                        err       <= 1'b1;
                        prm_valid <= 1'b1;
                    end else begin
                        work <= work_n;
                        used <= used_n;
                        rem  <= rem_n;
                        pos  <= pos + W'(1);
                        if (last) begin
                            prm       <= work_n;
                            err       <= 1'b0;
                            prm_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (prm_ready) prm_valid <= 1'b0;
                end
                default: begin
                    prm_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perm_decode.sv
// Directed bench for perm_decode (N=4): fixed vectors, range errors,
// backpressure, reset abort and a full ordered sweep.
module tb_perm_decode;

    logic       clk;
    logic       rst;
    logic       idx_valid;
    logic       idx_ready;
    logic [4:0] idx;
    logic       prm_valid;
    logic       prm_ready;
    logic [7:0] prm;
    logic       err;

    int tests;
    int fails;

    perm_decode #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx       (idx),
        .prm_valid (prm_valid),
        .prm_ready (prm_ready),
        .prm       (prm),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one rank through; stalls the result for 'stall' cycles.
    task automatic run_one(input logic [4:0] v, input int stall,
                           output logic [7:0] p, output logic e,
                           output int lat);
        int n;
        n = 0;
        p = 8'h00;
        e = 1'b0;
        lat = -1;
        while (!idx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (idx_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_wait idx=%0d idx_ready=%b want 1", v, idx_ready);
            return;
        end
        idx_valid = 1'b1;
        idx = v;
        @(posedge clk);
        @(negedge clk);
        idx_valid = 1'b0;
        prm_ready = (stall == 0);
        lat = 0;
        while (!prm_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        tests++;
        if (prm_valid !== 1'b1) begin
            fails++;
            $display("FAIL result_wait idx=%0d prm_valid=%b want 1", v, prm_valid);
            prm_ready = 1'b0;
            return;
        end
        p = prm;
        e = err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            tests++;
            if (prm !== p || err !== e || prm_valid !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold idx=%0d prm=%h err=%b v=%b want %h %b 1",
                         v, prm, err, prm_valid, p, e);
            end
        end
        prm_ready = 1'b1;
        @(negedge clk);
        prm_ready = 1'b0;
        tests++;
        if (prm_valid !== 1'b0 || idx_ready !== 1'b1) begin
            fails++;
            $display("FAIL release idx=%0d prm_valid=%b idx_ready=%b want 0 1",
                     v, prm_valid, idx_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idx_valid = 1'b0;
        idx = '0;
        prm_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (idx_ready !== 1'b0 || prm_valid !== 1'b0 || prm !== 8'h00 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals rdy=%b v=%b prm=%h err=%b want 0 0 00 0",
                     idx_ready, prm_valid, prm, err);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (idx_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_early idx_ready=%b want 0", idx_ready);
        end
        @(negedge clk);
        tests++;
        if (idx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_rise idx_ready=%b want 1", idx_ready);
        end
    endtask

    task automatic test_decode();
        logic [4:0] vi [4];
        logic [7:0] vp [4];
        logic [7:0] p;
        logic       e;
        int         lat;
        // fields LSB-first: 0123, 3210, 0132, 1302
        vi[0] = 5'd0;  vp[0] = 8'hE4;
        vi[1] = 5'd23; vp[1] = 8'h1B;
        vi[2] = 5'd1;  vp[2] = 8'hB4;
        vi[3] = 5'd10; vp[3] = 8'h8D;
        for (int k = 0; k < 4; k++) begin
            run_one(vi[k], 0, p, e, lat);
            tests++;
            if (p !== vp[k] || e !== 1'b0 || lat !== 4) begin
                fails++;
                $display("FAIL decode idx=%0d prm=%h err=%b lat=%0d want %h 0 4",
                         vi[k], p, e, lat, vp[k]);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [4:0] vi [2];
        logic [7:0] p;
        logic       e;
        int         lat;
        vi[0] = 5'd24;
        vi[1] = 5'd31;
        for (int k = 0; k < 2; k++) begin
            run_one(vi[k], 0, p, e, lat);
            tests++;
            if (p !== 8'hE4 || e !== 1'b1 || lat !== 1) begin
                fails++;
                $display("FAIL range idx=%0d prm=%h err=%b lat=%0d want e4 1 1",
                         vi[k], p, e, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        while (!idx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        idx_valid = 1'b1;
        idx = 5'd23;
        @(posedge clk);
        @(negedge clk);
        idx_valid = 1'b0;
        n = 0;
        while (!prm_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int s = 0; s < 5; s++) begin
            idx_valid = (s % 2 == 0);
            idx = 5'd3;
            @(negedge clk);
            tests++;
            if (prm !== 8'h1B || err !== 1'b0 || prm_valid !== 1'b1 || idx_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold prm=%h err=%b v=%b rdy=%b want 1b 0 1 0",
                         prm, err, prm_valid, idx_ready);
            end
        end
        idx_valid = 1'b0;
        prm_ready = 1'b1;
        @(negedge clk);
        prm_ready = 1'b0;
        tests++;
        if (idx_ready !== 1'b1 || prm_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release rdy=%b v=%b want 1 0", idx_ready, prm_valid);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (prm_valid !== 1'b0 || idx_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_phantom v=%b rdy=%b want 0 1", prm_valid, idx_ready);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] p;
        logic       e;
        int         lat;
        int         n;
        n = 0;
        while (!idx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        idx_valid = 1'b1;
        idx = 5'd10;
        @(posedge clk);
        @(negedge clk);
        idx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (idx_ready !== 1'b0 || prm_valid !== 1'b0 || prm !== 8'h00 || err !== 1'b0) begin
            fails++;
            $display("FAIL abort_vals rdy=%b v=%b prm=%h err=%b want 0 0 00 0",
                     idx_ready, prm_valid, prm, err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (idx_ready !== 1'b1 || prm_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_recover rdy=%b v=%b want 1 0", idx_ready, prm_valid);
        end
        // rank 5 -> fields 0,3,2,1
        run_one(5'd5, 0, p, e, lat);
        tests++;
        if (p !== 8'h6C || e !== 1'b0 || lat !== 4) begin
            fails++;
            $display("FAIL abort_next prm=%h err=%b lat=%0d want 6c 0 4", p, e, lat);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] p;
        logic       e;
        int         lat;
        int         key;
        int         prev;
        logic [3:0] seen;
        prev = -1;
        for (int v = 0; v < 24; v++) begin
            run_one(5'(v), int'($urandom_range(0, 3)), p, e, lat);
            seen = '0;
            for (int i = 0; i < 4; i++) seen[p[i*2 +: 2]] = 1'b1;
            key = {24'd0, p[1:0], p[3:2], p[5:4], p[7:6]};
            tests++;
            if (seen !== 4'hF || key <= prev || e !== 1'b0 || lat !== 4) begin
                fails++;
                $display("FAIL sweep idx=%0d prm=%h seen=%h key=%0d prev=%0d err=%b lat=%0d",
                         v, p, seen, key, prev, e, lat);
            end
            prev = key;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_decode();
        test_out_of_range();
        test_backpressure();
        test_reset_abort();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
